// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file and the write-enable decoder.
package reg_file_pkg;

    localparam int unsigned DATA_W       = 8;
    localparam int unsigned NUM_REGS_DEF = 16;
    localparam int unsigned ADDR_W_DEF   = 4;

    // Bit positions inside the 2-bit reg_file_wen bus
    localparam int unsigned WEN_TOP = 1;
    localparam int unsigned WEN_BOT = 0;

endpackage

// File: rtl/reg_file_bypass.sv
// Per-read-port priority mux: zero register, reset, top bypass, bottom bypass, stored value.
module reg_file_bypass
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              nreset,
    input  logic [1:0]        wen,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [ADDR_W-1:0] waddr_top,
    input  logic [DATA_W-1:0] wdata_top,
    input  logic [ADDR_W-1:0] waddr_bot,
    input  logic [DATA_W-1:0] wdata_bot,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rdata
);

    // Top is checked before bottom so the bypass matches what commits on a collision
    always_comb begin
        rdata = stored;
        if (ZERO_REG && raddr == '0) begin
            rdata = '0;
        end else if (!nreset) begin
            rdata = '0;
        end else if (wen[WEN_TOP] && raddr == waddr_top) begin
            rdata = wdata_top;
        end else if (wen[WEN_BOT] && raddr == waddr_bot) begin
            rdata = wdata_bot;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-write, two-read architectural register file with write-first bypass and async clear.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic [1:0]        wen,
    input  logic [ADDR_W-1:0] waddr_top,
    input  logic [DATA_W-1:0] wdata_top,
    input  logic [ADDR_W-1:0] waddr_bot,
    input  logic [DATA_W-1:0] wdata_bot,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              top_we;
    logic              bot_we;

    // Bottom yields to top on an address collision; register 0 may be hard-wired
    always_comb begin
        top_we = wen[WEN_TOP] && !(ZERO_REG && waddr_top == '0);
        bot_we = wen[WEN_BOT] && !(ZERO_REG && waddr_bot == '0)
                 && !(wen[WEN_TOP] && waddr_top == waddr_bot);
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (bot_we) begin
                regs_q[waddr_bot] <= wdata_bot;
            end
            if (top_we) begin
                regs_q[waddr_top] <= wdata_top;
            end
        end
    end

    reg_file_bypass #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_bypass_a (
        .nreset    (nreset),
        .wen       (wen),
        .raddr     (raddr_a),
        .waddr_top (waddr_top),
        .wdata_top (wdata_top),
        .waddr_bot (waddr_bot),
        .wdata_bot (wdata_bot),
        .stored    (regs_q[raddr_a]),
        .rdata     (rdata_a)
    );

    reg_file_bypass #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_bypass_b (
        .nreset    (nreset),
        .wen       (wen),
        .raddr     (raddr_b),
        .waddr_top (waddr_top),
        .wdata_top (wdata_top),
        .waddr_bot (waddr_bot),
        .wdata_bot (wdata_bot),
        .stored    (regs_q[raddr_b]),
        .rdata     (rdata_b)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: vector table plus reset corner sequences, scoreboard-checked.
module tb_reg_file;

    logic       clock = 1'b0;
    logic       nreset;
    logic [1:0] wen;
    logic [3:0] waddr_top, waddr_bot, raddr_a, raddr_b;
    logic [7:0] wdata_top, wdata_bot;
    logic [7:0] rdata_a, rdata_b, rdata_a_nz, rdata_b_nz;

    always #5 clock = ~clock;

    reg_file #(.NUM_REGS(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .wen       (wen),
        .waddr_top (waddr_top),
        .wdata_top (wdata_top),
        .waddr_bot (waddr_bot),
        .wdata_bot (wdata_bot),
        .raddr_a   (raddr_a),
        .rdata_a   (rdata_a),
        .raddr_b   (raddr_b),
        .rdata_b   (rdata_b)
    );

    reg_file #(.NUM_REGS(16), .ADDR_W(4), .ZERO_REG(1'b0)) dut_nz (
        .clock     (clock),
        .nreset    (nreset),
        .wen       (wen),
        .waddr_top (waddr_top),
        .wdata_top (wdata_top),
        .waddr_bot (waddr_bot),
        .wdata_bot (wdata_bot),
        .raddr_a   (raddr_a),
        .rdata_a   (rdata_a_nz),
        .raddr_b   (raddr_b),
        .rdata_b   (rdata_b_nz)
    );

    typedef struct {
        logic [1:0] w;
        logic [3:0] wt;
        logic [7:0] wdt;
        logic [3:0] wb;
        logic [7:0] wdb;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
    } vec_t;

    typedef struct packed {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] an;
        logic [7:0] bn;
    } exp_t;

    vec_t       vecs [13];
    exp_t       sb [$];
    logic [7:0] m1 [16];  // model with zero register
    logic [7:0] m0 [16];  // model without zero register
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            m1[i] = 8'h00;
            m0[i] = 8'h00;
        end
    endtask

    function automatic logic [7:0] model_rd(input bit z, input logic [3:0] a);
        if (z && a == 4'd0) return 8'h00;
        if (!nreset) return 8'h00;
        if (wen[1] && a == waddr_top) return wdata_top;
        if (wen[0] && a == waddr_bot) return wdata_bot;
        return z ? m1[a] : m0[a];
    endfunction

    // Bottom first, then top, so top wins a collision
    task automatic commit_models();
        if (wen[0]) begin
            if (waddr_bot != 4'd0) m1[waddr_bot] = wdata_bot;
            m0[waddr_bot] = wdata_bot;
        end
        if (wen[1]) begin
            if (waddr_top != 4'd0) m1[waddr_top] = wdata_top;
            m0[waddr_top] = wdata_top;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input int id, input logic [1:0] w, input logic [3:0] wt,
                        input logic [7:0] wdt, input logic [3:0] wb, input logic [7:0] wdb,
                        input logic [3:0] ra, input logic [3:0] rb, input bit use_tab,
                        input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        wen = w; waddr_top = wt; wdata_top = wdt; waddr_bot = wb; wdata_bot = wdb;
        raddr_a = ra; raddr_b = rb;
        e.id = id;
        e.a  = use_tab ? ea : model_rd(1'b1, ra);
        e.b  = use_tab ? eb : model_rd(1'b1, rb);
        e.an = model_rd(1'b0, ra);
        e.bn = model_rd(1'b0, rb);
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk($sformatf("s%0d_a", e.id), rdata_a, e.a);
        chk($sformatf("s%0d_b", e.id), rdata_b, e.b);
        chk($sformatf("s%0d_a_nz", e.id), rdata_a_nz, e.an);
        chk($sformatf("s%0d_b_nz", e.id), rdata_b_nz, e.bn);
        @(posedge clock);
        if (nreset) commit_models();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b11, 4'd3,  8'h12, 4'd7,  8'h34, 4'd3,  4'd7,  8'h12, 8'h34};
        vecs[1]  = '{2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 4'd3,  4'd7,  8'h12, 8'h34};
        vecs[2]  = '{2'b11, 4'd5,  8'hAA, 4'd5,  8'h55, 4'd5,  4'd5,  8'hAA, 8'hAA};
        vecs[3]  = '{2'b00, 4'd5,  8'h00, 4'd5,  8'h00, 4'd5,  4'd5,  8'hAA, 8'hAA};
        vecs[4]  = '{2'b10, 4'd9,  8'h01, 4'd9,  8'hEE, 4'd9,  4'd3,  8'h01, 8'h12};
        vecs[5]  = '{2'b01, 4'd9,  8'h33, 4'd9,  8'hF0, 4'd9,  4'd9,  8'hF0, 8'hF0};
        vecs[6]  = '{2'b00, 4'd9,  8'h00, 4'd9,  8'h00, 4'd9,  4'd9,  8'hF0, 8'hF0};
        vecs[7]  = '{2'b11, 4'd0,  8'hFF, 4'd0,  8'hFF, 4'd0,  4'd0,  8'h00, 8'h00};
        vecs[8]  = '{2'b00, 4'd0,  8'h00, 4'd0,  8'h00, 4'd0,  4'd0,  8'h00, 8'h00};
        vecs[9]  = '{2'b11, 4'd15, 8'hC3, 4'd14, 8'h3C, 4'd14, 4'd15, 8'h3C, 8'hC3};
        vecs[10] = '{2'b01, 4'd1,  8'h00, 4'd0,  8'h77, 4'd0,  4'd7,  8'h00, 8'h34};
        vecs[11] = '{2'b10, 4'd7,  8'h99, 4'd1,  8'h00, 4'd7,  4'd14, 8'h99, 8'h3C};
        vecs[12] = '{2'b00, 4'd7,  8'h00, 4'd7,  8'h00, 4'd7,  4'd15, 8'h99, 8'hC3};

        wen = 2'b00; waddr_top = '0; wdata_top = '0; waddr_bot = '0; wdata_bot = '0;
        raddr_a = 4'd3; raddr_b = 4'd7;
        nreset = 1'b1;
        #1 nreset = 1'b0;
        clear_models();
        #1;
        chk("rst_a", rdata_a, 8'h00);
        chk("rst_b", rdata_b, 8'h00);
        chk("rst_a_nz", rdata_a_nz, 8'h00);
        chk("rst_b_nz", rdata_b_nz, 8'h00);
        @(negedge clock);
        nreset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(i, vecs[i].w, vecs[i].wt, vecs[i].wdt, vecs[i].wb, vecs[i].wdb,
                 vecs[i].ra, vecs[i].rb, 1'b1, vecs[i].ea, vecs[i].eb);
        end

        // Load every register, then clear between edges with no clock edge in the pulse
        for (int i = 0; i < 16; i++) begin
            step(100 + i, 2'b10, 4'(i), 8'hA5, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b0, 8'h00,
                 8'h00);
        end
        step(120, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'd4, 4'd15, 1'b1, 8'hA5, 8'hA5);
        #2 nreset = 1'b0;
        clear_models();
        #1;
        chk("async_a", rdata_a, 8'h00);
        chk("async_b_nz", rdata_b_nz, 8'h00);
        #1 nreset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 16; i++) begin
            step(130 + i, 2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 4'(i), 4'(15 - i), 1'b1, 8'h00,
                 8'h00);
        end

        // Reset held across an edge overrides a write
        nreset = 1'b0;
        clear_models();
        step(200, 2'b10, 4'd2, 8'h77, 4'd0, 8'h00, 4'd2, 4'd2, 1'b1, 8'h00, 8'h00);
        nreset = 1'b1;
        step(201, 2'b00, 4'd2, 8'h00, 4'd2, 8'h00, 4'd2, 4'd2, 1'b1, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
